// File: rtl/nlc_pkg.sv
// Shared constants and types for the NLC result path.
package nlc_pkg;

    localparam int unsigned NUM_CH      = 16;
    localparam int unsigned ADC_W       = 21;
    localparam int unsigned FP_W        = 32;
    localparam int unsigned FP_EXP_BIAS = 127;
    localparam int unsigned FP_MANT_W   = 23;
    localparam int unsigned IDX_W       = $clog2(NUM_CH);

    // Saturation bounds of the 21-bit two's complement x_lin format
    localparam logic [ADC_W-1:0] ADC_MAX = 21'h0FFFFF;
    localparam logic [ADC_W-1:0] ADC_MIN = 21'h100000;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

endpackage

// File: rtl/nlc_fp_to_fixed.sv
// IEEE-754 single to 21-bit signed integer, truncating toward zero with
// saturation; NaN maps to zero and is flagged.
module nlc_fp_to_fixed
    import nlc_pkg::*;
(
    input  logic [FP_W-1:0]  fp,
    output logic [ADC_W-1:0] x_lin,
    output logic             is_nan
);

    logic                 sign;
    logic [7:0]           exp_f;
    logic [FP_MANT_W-1:0] frac;
    logic [FP_MANT_W:0]   mant;
    logic [4:0]           shamt;
    logic [ADC_W-1:0]     mag;

    assign sign  = fp[FP_W-1];
    assign exp_f = fp[FP_W-2:FP_MANT_W];
    assign frac  = fp[FP_MANT_W-1:0];
    assign mant  = {1'b1, frac};

    always_comb begin
        x_lin  = '0;
        is_nan = 1'b0;
        shamt  = '0;
        mag    = '0;
        if (exp_f == 8'hFF) begin
            if (frac != '0) begin
                is_nan = 1'b1;
            end else begin
                x_lin = sign ? ADC_MIN : ADC_MAX;
            end
        end else if (exp_f >= 8'(FP_EXP_BIAS + ADC_W - 1)) begin
            x_lin = sign ? ADC_MIN : ADC_MAX;
        end else if (exp_f >= 8'(FP_EXP_BIAS)) begin
            // unbiased exponent 0..19 -> right shift of 23..4
            shamt = 5'(8'(FP_EXP_BIAS + FP_MANT_W) - exp_f);
            mag   = ADC_W'(mant >> shamt);
            x_lin = sign ? (~mag + 1'b1) : mag;
        end
    end

endmodule

// File: rtl/nlc_result_collector.sv
// Collects the per-channel float stream from the adder, converts to x_lin
// and deserialises it into the packed channel bus; pulses srdyo per frame.
module nlc_result_collector
    import nlc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    srdyi,
    input  logic [FP_W-1:0]         data_in,
    input  logic                    data_srdyi,
    output logic [NUM_CH*ADC_W-1:0] x_lin_bus,
    output logic                    srdyo,
    output logic                    busy,
    output logic                    err_overrun,
    output logic                    err_nan,
    output logic                    err_restart
);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx, eff_idx;
    logic             accept, last, overrun, restart;

    logic [ADC_W-1:0] conv;
    logic             conv_nan;

    logic             stg_valid, stg_last;
    logic [IDX_W-1:0] stg_idx;
    logic [ADC_W-1:0] stg_data;

    nlc_fp_to_fixed u_conv (
        .fp     (data_in),
        .x_lin  (conv),
        .is_nan (conv_nan)
    );

    // srdyi is applied before the sample, so a coincident sample lands as ch0
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        eff_idx  = srdyi ? '0 : idx;
        accept   = data_srdyi && (srdyi || (state == COLLECT));
        last     = accept && (eff_idx == IDX_W'(NUM_CH - 1));
        overrun  = data_srdyi && !accept;
        restart  = srdyi && (state != IDLE);

        if (srdyi) begin
            state_nx = COLLECT;
            idx_nx   = '0;
        end else if (state == DRAIN) begin
            state_nx = IDLE;
        end

        if (accept) begin
            if (last) begin
                idx_nx   = '0;
                state_nx = DRAIN;
            end else begin
                idx_nx = eff_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            stg_valid   <= 1'b0;
            stg_last    <= 1'b0;
            stg_idx     <= '0;
            stg_data    <= '0;
            x_lin_bus   <= '0;
            srdyo       <= 1'b0;
            err_overrun <= 1'b0;
            err_nan     <= 1'b0;
            err_restart <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            stg_valid <= accept;
            stg_last  <= last;
            if (accept) begin
                stg_idx  <= eff_idx;
                stg_data <= conv;
            end
            // an in-flight write finishes to its own channel even across a restart
            if (stg_valid) begin
                x_lin_bus[stg_idx*ADC_W +: ADC_W] <= stg_data;
            end
            srdyo <= stg_valid && stg_last;
            if (overrun) begin
                err_overrun <= 1'b1;
            end
            if (accept && conv_nan) begin
                err_nan <= 1'b1;
            end
            if (restart) begin
                err_restart <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
